// File: rtl/aclk_keypad_scanner.sv
// 4x3 matrix keypad scanner: column scan, per-frame decode and press/release
// debounce producing a registered key code with a one-clock press strobe.
module aclk_keypad_scanner #(
   parameter int unsigned SCAN_DIV       = 16,
   parameter int unsigned DEBOUNCE_SCANS = 4,
   parameter logic [3:0]  NOKEY          = 4'd10
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] row,
   output logic [2:0] col,
   output logic [3:0] key,
   output logic       key_strobe
);

   localparam int unsigned      DIV_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCAN_DIV - 1);
   localparam logic [3:0]       DEB_TARGET = 4'(DEBOUNCE_SCANS);

   typedef enum logic [1:0] {IDLE, PRESS_CHK, PRESSED, REL_CHK} state_t;

   logic [3:0]       row_s1, row_s2;
   logic [DIV_W-1:0] div;
   logic [1:0]       col_sel;
   logic [2:0]       col_next;
   logic [11:0]      frame_mask, col_hits, mask_now;
   logic             sample, frame_end;
   logic [3:0]       n_down, hit_idx, frame_code;

   state_t     state, state_n;
   logic [3:0] cand, cand_n, cnt, cnt_n, cnt_inc, key_n;
   logic       strobe_n;

   assign sample    = (div == DIV_LAST);
   assign frame_end = sample && (col_sel == 2'd2);

   always_comb begin
      case (col_sel)
         2'd0:    col_next = 3'b101;
         2'd1:    col_next = 3'b011;
         default: col_next = 3'b110;
      endcase
   end

   // Keys seen in the currently driven column; bit index is row*3+column
   always_comb begin
      col_hits = '0;
      for (int r = 0; r < 4; r++) begin
         case (col_sel)
            2'd0:    col_hits[r*3]   = ~row_s2[r];
            2'd1:    col_hits[r*3+1] = ~row_s2[r];
            default: col_hits[r*3+2] = ~row_s2[r];
         endcase
      end
   end

   assign mask_now = frame_mask | col_hits;

   // Exactly one key down, and it must be a digit (not * or #)
   always_comb begin
      n_down  = 4'd0;
      hit_idx = 4'd0;
      for (int i = 0; i < 12; i++) begin
         if (mask_now[i]) begin
            n_down  = 4'(n_down + 4'd1);
            hit_idx = 4'(i);
         end
      end
      frame_code = NOKEY;
      if (n_down == 4'd1) begin
         if (hit_idx < 4'd9)        frame_code = 4'(hit_idx + 4'd1);
         else if (hit_idx == 4'd10) frame_code = 4'd0;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         row_s1     <= 4'b1111;
         row_s2     <= 4'b1111;
         div        <= '0;
         col_sel    <= 2'd0;
         col        <= 3'b110;
         frame_mask <= '0;
      end else begin
         row_s1 <= row;
         row_s2 <= row_s1;
         if (sample) begin
            div        <= '0;
            col_sel    <= (col_sel == 2'd2) ? 2'd0 : 2'(col_sel + 2'd1);
            col        <= col_next;
            frame_mask <= frame_end ? 12'd0 : mask_now;
         end else begin
            div <= div + DIV_W'(1);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state      <= IDLE;
         cand       <= NOKEY;
         cnt        <= 4'd0;
         key        <= NOKEY;
         key_strobe <= 1'b0;
      end else begin
         state      <= state_n;
         cand       <= cand_n;
         cnt        <= cnt_n;
         key        <= key_n;
         key_strobe <= strobe_n;
      end
   end

   // Debounce decisions happen only once per frame
   always_comb begin
      state_n  = state;
      cand_n   = cand;
      cnt_n    = cnt;
      key_n    = key;
      strobe_n = 1'b0;
      cnt_inc  = 4'(cnt + 4'd1);
      if (frame_end) begin
         case (state)
            IDLE: begin
               if (frame_code != NOKEY) begin
                  cand_n = frame_code;
                  if (DEB_TARGET == 4'd1) begin
                     state_n  = PRESSED;
                     cnt_n    = 4'd0;
                     key_n    = frame_code;
                     strobe_n = 1'b1;
                  end else begin
                     state_n = PRESS_CHK;
                     cnt_n   = 4'd1;
                  end
               end
            end
            PRESS_CHK: begin
               if (frame_code == cand) begin
                  if (cnt_inc == DEB_TARGET) begin
                     state_n  = PRESSED;
                     cnt_n    = 4'd0;
                     key_n    = cand;
                     strobe_n = 1'b1;
                  end else begin
                     cnt_n = cnt_inc;
                  end
               end else begin
                  state_n = IDLE;
                  cnt_n   = 4'd0;
               end
            end
            PRESSED: begin
               if (frame_code != cand) begin
                  if (DEB_TARGET == 4'd1) begin
                     state_n = IDLE;
                     cnt_n   = 4'd0;
                     key_n   = NOKEY;
                  end else begin
                     state_n = REL_CHK;
                     cnt_n   = 4'd1;
                  end
               end
            end
            REL_CHK: begin
               if (frame_code != cand) begin
                  if (cnt_inc == DEB_TARGET) begin
                     state_n = IDLE;
                     cnt_n   = 4'd0;
                     key_n   = NOKEY;
                  end else begin
                     cnt_n = cnt_inc;
                  end
               end else begin
                  state_n = PRESSED;
                  cnt_n   = 4'd0;
               end
            end
            default: begin
               state_n = IDLE;
               cnt_n   = 4'd0;
               key_n   = NOKEY;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_aclk_keypad_scanner.sv
// Directed bench for aclk_keypad_scanner with a behavioural 4x3 keypad model;
// SCAN_DIV=4, DEBOUNCE_SCANS=2, so one frame is 12 clocks.
module tb_aclk_keypad_scanner;

   logic       clock = 1'b0;
   logic       reset;
   logic [3:0] row;
   logic [2:0] col;
   logic [3:0] key;
   logic       key_strobe;
   logic [11:0] held;

   int n_checks = 0;
   int n_fail   = 0;
   int strobe_cnt = 0;

   aclk_keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2)) dut (
      .clock      (clock),
      .reset      (reset),
      .row        (row),
      .col        (col),
      .key        (key),
      .key_strobe (key_strobe)
   );

   always #5 clock = ~clock;

   // Keypad: row r pulled low while column c is driven low and key (r,c) held
   always_comb begin
      row = 4'b1111;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 3; c++)
            if (!col[c] && held[r*3+c]) row[r] = 1'b0;
   end

   always @(negedge clock) if (key_strobe === 1'b1) strobe_cnt <= strobe_cnt + 1;

   typedef struct {
      string       name;
      logic [11:0] held;
      int          exp_key;
   } vec_t;

   vec_t vecs[7];

   // Key position bit: digits 1-9 rows 0-2, 10 = '*', 0 = '0', 11 = '#'
   function automatic logic [11:0] kb(input int d);
      logic [11:0] one = 12'd1;
      if (d >= 1 && d <= 9) return one << (d - 1);
      if (d == 0)           return one << 10;
      if (d == 10)          return one << 9;
      return one << 11;
   endfunction

   task automatic step(input int n);
      repeat (n) @(posedge clock);
      @(negedge clock);
   endtask

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b0;
      step(3);
      reset = 1'b1;
   endtask

   initial begin
      logic [2:0] exp_cols [3];
      int base;
      int bad;

      exp_cols[0] = 3'b110;
      exp_cols[1] = 3'b101;
      exp_cols[2] = 3'b011;

      vecs[0] = '{"one",        kb(1),          1};
      vecs[1] = '{"nine",       kb(9),          9};
      vecs[2] = '{"zero",       kb(0),          0};
      vecs[3] = '{"one_nine",   kb(1) | kb(9),  10};
      vecs[4] = '{"star",       kb(10),         10};
      vecs[5] = '{"hash_zero",  kb(11) | kb(0), 10};
      vecs[6] = '{"six",        kb(6),          6};

      reset = 1'b0;
      held  = '0;

      // Reset values and column scan order
      step(3);
      reset = 1'b1;
      check("rst_key", int'(key), 10);
      check("rst_strobe", int'(key_strobe), 0);
      for (int i = 0; i < 12; i++) begin
         check($sformatf("col_seq%0d", i), int'(col), int'(exp_cols[i/4]));
         step(1);
      end

      // Steady single patterns from a frame-aligned start
      foreach (vecs[v]) begin
         do_reset();
         held = vecs[v].held;
         base = strobe_cnt;
         step(23);
         check({vecs[v].name, "_early"}, int'(key), 10);
         step(1);
         check({vecs[v].name, "_key"}, int'(key), vecs[v].exp_key);
         step(2);
         check({vecs[v].name, "_strobes"}, strobe_cnt - base, (vecs[v].exp_key != 10) ? 1 : 0);
         held = '0;
      end

      // Press and release of '5'
      do_reset();
      held = kb(5);
      base = strobe_cnt;
      step(23);
      check("p5_early", int'(key), 10);
      step(1);
      check("p5_key", int'(key), 5);
      check("p5_strobe", int'(key_strobe), 1);
      held = '0;
      step(23);
      check("r5_hold", int'(key), 5);
      step(1);
      check("r5_key", int'(key), 10);
      check("r5_strobe", int'(key_strobe), 0);
      step(2);
      check("p5_strobes", strobe_cnt - base, 1);

      // '7' bouncing on alternate frames never qualifies
      do_reset();
      base = strobe_cnt;
      bad  = 0;
      for (int f = 0; f < 8; f++) begin
         held = (f % 2 == 0) ? kb(7) : 12'd0;
         for (int c = 0; c < 12; c++) begin
            step(1);
            if (key != 4'd10) bad++;
         end
      end
      held = '0;
      step(2);
      check("alt7_bad_cycles", bad, 0);
      check("alt7_strobes", strobe_cnt - base, 0);

      // Direct change 2 -> 3 passes through NOKEY
      do_reset();
      held = kb(2);
      base = strobe_cnt;
      step(24);
      check("chg_key2", int'(key), 2);
      held = kb(3);
      step(23);
      check("chg_hold2", int'(key), 2);
      step(1);
      check("chg_gap", int'(key), 10);
      step(23);
      check("chg_gap_hold", int'(key), 10);
      step(1);
      check("chg_key3", int'(key), 3);
      step(2);
      check("chg_strobes", strobe_cnt - base, 2);
      held = '0;

      // Reset during PRESS_CHK discards the partial debounce
      do_reset();
      held = kb(8);
      step(16);
      reset = 1'b0;
      step(1);
      check("mid_rst_key", int'(key), 10);
      check("mid_rst_col", int'(col), int'(3'b110));
      check("mid_rst_strobe", int'(key_strobe), 0);
      step(2);
      reset = 1'b1;
      base = strobe_cnt;
      step(23);
      check("post_rst_early", int'(key), 10);
      step(1);
      check("post_rst_key", int'(key), 8);
      step(2);
      check("post_rst_strobes", strobe_cnt - base, 1);
      held = '0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
